qm_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives every input combination into the team's minimized 11-input sum-of-products functions and checks the result. It compares a candidate implementation (`func_a`) against a golden implementation (`func_b`), such as a canonical minterm expansion. It counts the function's on-set and the mismatches, and records the first failing vector. It sits above the two purely combinational function instances and below the lab top-level's start/status logic.

---
 rtl/qm_sweep_ctrl.sv | 110 +++++++++++
 tb/tb_qm_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/qm_sweep_ctrl.sv
// rtl/qm_sweep_ctrl.sv - exhaustive sweep sequencer comparing a candidate SOP function against a golden one
module qm_sweep_ctrl #(
  parameter int N = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         hold,
  output logic [N-1:0] vec,
  input  logic         func_a,
  input  logic         func_b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_cnt,
  output logic [N:0]   mism_cnt,
  output logic         any_mism,
  output logic [N-1:0] first_mism
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
  localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};

  state_t state, state_nx;
  logic   clear;
  logic   advance;

  logic [N-1:0] s1_vec;
  logic         s1_a;
  logic         s1_b;
  logic         s1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clear    = 1'b1;
          state_nx = SWEEP;
        end
      end
      SWEEP: begin
        // the last vector is issued once; vec parks at all-ones instead of wrapping
        if (!hold) begin
          if (vec == VEC_LAST) state_nx = DRAIN;
          else                 advance  = 1'b1;
        end
      end
      DRAIN:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SWEEP) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n)       vec <= '0;
    else if (clear)   vec <= '0;
    else if (advance) vec <= vec + {{(N-1){1'b0}}, 1'b1};
  end

  // a held cycle captures with valid low so the stalled vector is counted once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vec   <= '0;
      s1_a     <= 1'b0;
      s1_b     <= 1'b0;
      s1_valid <= 1'b0;
    end else if (state == SWEEP) begin
      s1_vec   <= vec;
      s1_a     <= func_a;
      s1_b     <= func_b;
      s1_valid <= ~hold;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ones_cnt   <= '0;
      mism_cnt   <= '0;
      first_mism <= '0;
    end else if (s1_valid) begin
      ones_cnt <= ones_cnt + {{N{1'b0}}, s1_a};
      if (s1_a != s1_b) begin
        mism_cnt <= mism_cnt + CNT_ONE;
        // vectors arrive in ascending order, so the first mismatch is the lowest
        if (mism_cnt == '0) first_mism <= s1_vec;
      end
    end
  end

  assign any_mism = (mism_cnt != '0);

endmodule

// File: tb/tb_qm_sweep_ctrl.sv
// tb/tb_qm_sweep_ctrl.sv - self-checking bench for qm_sweep_ctrl against a truth-table reference model
module tb_qm_sweep_ctrl;

  localparam int N  = 11;
  localparam int NV = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic [N-1:0] vec;
  logic         func_a;
  logic         func_b;
  logic         busy;
  logic         done;
  logic [N:0]   ones_cnt;
  logic [N:0]   mism_cnt;
  logic         any_mism;
  logic [N-1:0] first_mism;

  bit ta [0:NV-1];
  bit tb [0:NV-1];

  int checks = 0;
  int errors = 0;
  int exp_ones, exp_mism, exp_first, exp_any;
  bit hold_rand = 1'b0;

  qm_sweep_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hold       (hold),
    .vec        (vec),
    .func_a     (func_a),
    .func_b     (func_b),
    .busy       (busy),
    .done       (done),
    .ones_cnt   (ones_cnt),
    .mism_cnt   (mism_cnt),
    .any_mism   (any_mism),
    .first_mism (first_mism)
  );

  always #5 clk = ~clk;

  assign func_a = ta[vec];
  assign func_b = tb[vec];

  always @(negedge clk) begin
    if (hold_rand) hold = busy && ($urandom_range(0, 3) == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // minimized candidate: a b ~c + ~a d e f + g h ~i j + b c d ~k ; drop removes one term
  function automatic bit f_min(input logic [10:0] v, input int drop);
    bit t0, t1, t2, t3;
    t0 = v[10] & v[9] & ~v[8];
    t1 = ~v[10] & v[7] & v[6] & v[5];
    t2 = v[4] & v[3] & ~v[2] & v[1];
    t3 = v[9] & v[8] & v[7] & ~v[0];
    if (drop == 0) t0 = 1'b0;
    if (drop == 1) t1 = 1'b0;
    if (drop == 2) t2 = 1'b0;
    if (drop == 3) t3 = 1'b0;
    return t0 | t1 | t2 | t3;
  endfunction

  // golden: minterm is on if any cube (mask/value) covers it
  function automatic bit f_canon(input logic [10:0] v);
    logic [10:0] mask [4];
    logic [10:0] val  [4];
    mask[0] = 11'b111_0000_0000; val[0] = 11'b110_0000_0000;
    mask[1] = 11'b100_1110_0000; val[1] = 11'b000_1110_0000;
    mask[2] = 11'b000_0001_1110; val[2] = 11'b000_0001_1010;
    mask[3] = 11'b011_1000_0001; val[3] = 11'b011_1000_0000;
    for (int c = 0; c < 4; c++)
      if ((v & mask[c]) == val[c]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_model;
    exp_ones = 0; exp_mism = 0; exp_first = 0;
    for (int i = 0; i < NV; i++) begin
      exp_ones += int'(ta[i]);
      if (ta[i] != tb[i]) begin
        if (exp_mism == 0) exp_first = i;
        exp_mism++;
      end
    end
    exp_any = (exp_mism != 0) ? 1 : 0;
  endtask

  task automatic set_tables(input int mode, input int drop);
    for (int i = 0; i < NV; i++) begin
      case (mode)
        0: begin ta[i] = 1'b1; tb[i] = 1'b1; end
        1: begin ta[i] = 1'b0; tb[i] = i[0]; end
        2: begin ta[i] = 1'b1; tb[i] = 1'b0; end
        3: begin ta[i] = f_min(11'(i), drop); tb[i] = f_canon(11'(i)); end
        default: begin
          ta[i] = 1'($urandom_range(0, 1));
          tb[i] = ta[i] ^ ($urandom_range(0, 15) == 0);
        end
      endcase
    end
    build_model();
  endtask

  task automatic wait_vec(input int v);
    int n = 0;
    @(negedge clk);
    while (int'(vec) != v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_vec", vec, v);
  endtask

  task automatic run_sweep(input string tag, input int exp_cyc);
    int c;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 1;
    @(negedge clk);
    while (!done && c < 6000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, done, 1);
    if (exp_cyc > 0) check({tag, "_cycles"}, c, exp_cyc);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ones"}, ones_cnt, exp_ones);
    check({tag, "_mism"}, mism_cnt, exp_mism);
    check({tag, "_any"}, any_mism, exp_any);
    check({tag, "_first"}, first_mism, exp_first);
  endtask

  initial begin
    // reset with start asserted must stay idle
    rst_n = 1'b0;
    start = 1'b1;
    set_tables(0, -1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vec", vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones_cnt, 0);
    check("rst_mism", mism_cnt, 0);
    check("rst_any", any_mism, 0);
    check("rst_first", first_mism, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    set_tables(0, -1);
    run_sweep("tie1", 2050);

    set_tables(1, -1);
    run_sweep("alt", 2050);

    set_tables(2, -1);
    fork
      run_sweep("hold", 2055);
      begin
        wait_vec(100);
        hold = 1'b1;
        repeat (5) @(posedge clk);
        #1 hold = 1'b0;
      end
    join

    set_tables(3, -1);
    run_sweep("real", 2050);
    set_tables(3, 2);
    run_sweep("fault", 2050);

    set_tables(4, -1);
    hold_rand = 1'b1;
    run_sweep("rand_hold", -1);
    hold_rand = 1'b0;
    hold = 1'b0;

    set_tables(4, -1);
    fork
      run_sweep("mid_start", 2050);
      begin
        wait_vec(500);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    run_sweep("restart", 2050);

    set_tables(0, -1);
    fork
      begin
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      wait_vec(1000);
    join
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mrst_vec", vec, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ones", ones_cnt, 0);
    check("mrst_mism", mism_cnt, 0);
    repeat (3) @(negedge clk);
    check("mrst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
